// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor:
// control-flow type encoding, BTB entry layout and counter initial value.
package bp_pkg;

   typedef enum logic [2:0] {
      BP_BR   = 3'd0,
      BP_JAL  = 3'd1,
      BP_JALR = 3'd2,
      BP_CALL = 3'd3,
      BP_RET  = 3'd4
   } bp_type_t;

   // Tag is the PC shifted right past the index and byte-offset bits, so the
   // unused upper bits of the field are always zero and compare equal.
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
      bp_type_t    btype;
      logic [31:0] target;
   } btb_entry_t;

   // Weakly-not-taken starting value for an N-bit saturating counter.
   function automatic int unsigned ctr_init(input int unsigned bits);
      if (bits <= 1) begin
         return 0;
      end
      return (32'd1 << (bits - 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/bp_ras.sv
// Return-address stack: non-speculative, circular. A push onto a full stack
// overwrites the oldest entry; a pop of an empty stack does nothing.
module bp_ras
   import bp_pkg::*;
#(
   parameter int RAS_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_i,
   input  logic [31:0] push_data_i,
   input  logic        pop_i,
   output logic [31:0] top_o,
   output logic        empty_o
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(RAS_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RAS_DEPTH);

   logic [31:0]      ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] top_ptr;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // ptr_q is the next free slot; the top lives one slot below it (wrapping).
   always_comb begin
      top_ptr = (ptr_q == '0) ? LAST_SLOT : ptr_q - 1'b1;
   end

   // Next pointer/count: push wraps and saturates the count, pop never underflows.
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push_i) begin
         ptr_d = (ptr_q == LAST_SLOT) ? '0 : ptr_q + 1'b1;
         if (cnt_q != FULL_CNT) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (pop_i && (cnt_q != '0)) begin
         ptr_d = top_ptr;
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // Stack storage: data only, never reset; a reset cycle writes nothing.
   always_ff @(posedge clk) begin
      if (rst_n && push_i) begin
         ras_mem[ptr_q] <= push_data_i;
      end
   end

   assign top_o   = ras_mem[top_ptr];
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/branch_predictor_gshare.sv
// Fetch-stage predictor: tagged BTB, gshare PHT of saturating counters and a
// return-address stack. Prediction is combinational off pc_i; execute writes
// back one resolved control-flow op per cycle, visible to fetch next cycle.
module branch_predictor_gshare
   import bp_pkg::*;
#(
   parameter int BTB_ENTRIES  = 64,
   parameter int PHT_ENTRIES  = 512,
   parameter int COUNTER_BITS = 2,
   parameter int GHR_BITS     = 8,
   parameter int USE_GSHARE   = 1,
   parameter int RAS_DEPTH    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         pc_i,
   input  logic                fetch_valid_i,
   output logic                predict_taken_o,
   output logic [31:0]         predict_target_o,
   output logic [GHR_BITS-1:0] predict_ghr_o,
   input  logic                resolve_valid_i,
   input  bp_type_t            resolve_type_i,
   input  logic [31:0]         resolve_pc_i,
   input  logic [31:0]         resolve_target_i,
   input  logic                resolve_taken_i,
   input  logic [GHR_BITS-1:0] resolve_ghr_i
);

   localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
   localparam int PHT_IDX_W = $clog2(PHT_ENTRIES);
   localparam logic [COUNTER_BITS-1:0] CTR_INIT = COUNTER_BITS'(ctr_init(COUNTER_BITS));
   localparam logic [COUNTER_BITS-1:0] CTR_MAX  = '1;

   function automatic logic [COUNTER_BITS-1:0] sat_inc(input logic [COUNTER_BITS-1:0] c);
      return (c == CTR_MAX) ? c : c + COUNTER_BITS'(1);
   endfunction

   function automatic logic [COUNTER_BITS-1:0] sat_dec(input logic [COUNTER_BITS-1:0] c);
      return (c == '0) ? c : c - COUNTER_BITS'(1);
   endfunction

   btb_entry_t              btb_mem [BTB_ENTRIES];
   logic [COUNTER_BITS-1:0] pht_mem [PHT_ENTRIES];
   logic [GHR_BITS-1:0]     ghr_q, ghr_d;

   logic [BTB_IDX_W-1:0]    fetch_idx, res_idx;
   logic [31:0]             fetch_tag, res_tag;
   logic [PHT_IDX_W-1:0]    fetch_hist, res_hist;
   logic [PHT_IDX_W-1:0]    fetch_pidx, res_pidx;
   btb_entry_t              fetch_entry;
   logic                    fetch_hit;

   logic                    btb_we;
   btb_entry_t              btb_wdata;
   logic                    pht_we;
   logic [COUNTER_BITS-1:0] pht_wdata;

   logic                    ras_push, ras_pop;
   logic [31:0]             ras_push_data;
   logic [31:0]             ras_top;
   logic                    ras_empty;

   // Bit 0 of the PCs is below instruction granularity; the returned history
   // only matters when gshare hashing is enabled.
   logic unused_bits;
   assign unused_bits = ^{pc_i[0], resolve_pc_i[0], resolve_ghr_i};

   assign fetch_idx  = pc_i[BTB_IDX_W:1];
   assign res_idx    = resolve_pc_i[BTB_IDX_W:1];
   assign fetch_tag  = pc_i >> (BTB_IDX_W + 1);
   assign res_tag    = resolve_pc_i >> (BTB_IDX_W + 1);

   // History is zero-extended into the PHT index; with hashing off it drops out.
   assign fetch_hist = (USE_GSHARE != 0) ? PHT_IDX_W'(ghr_q) : '0;
   assign res_hist   = (USE_GSHARE != 0) ? PHT_IDX_W'(resolve_ghr_i) : '0;
   assign fetch_pidx = pc_i[PHT_IDX_W:1] ^ fetch_hist;
   assign res_pidx   = resolve_pc_i[PHT_IDX_W:1] ^ res_hist;

   assign predict_ghr_o = ghr_q;

   // Prediction: BTB lookup qualified by tag and fetch_valid_i, then per-type direction/target.
   always_comb begin
      fetch_entry      = btb_mem[fetch_idx];
      fetch_hit        = fetch_valid_i && fetch_entry.valid && (fetch_entry.tag == fetch_tag);
      predict_taken_o  = 1'b0;
      predict_target_o = '0;
      if (fetch_hit) begin
         predict_target_o = fetch_entry.target;
         case (fetch_entry.btype)
            BP_BR: begin
               predict_taken_o = pht_mem[fetch_pidx][COUNTER_BITS-1];
            end
            BP_RET: begin
               predict_taken_o = 1'b1;
               if (!ras_empty) begin
                  predict_target_o = ras_top;
               end
            end
            default: begin
               predict_taken_o = 1'b1;
            end
         endcase
      end
   end

   // Resolve write-back: BTB fill on taken ops, PHT/GHR training on branches, RAS push/pop.
   always_comb begin
      btb_we           = resolve_valid_i && resolve_taken_i;
      btb_wdata        = '0;
      btb_wdata.valid  = 1'b1;
      btb_wdata.tag    = res_tag;
      btb_wdata.btype  = resolve_type_i;
      btb_wdata.target = resolve_target_i;

      pht_we    = resolve_valid_i && (resolve_type_i == BP_BR);
      pht_wdata = resolve_taken_i ? sat_inc(pht_mem[res_pidx]) : sat_dec(pht_mem[res_pidx]);

      ghr_d = ghr_q;
      if (pht_we && (USE_GSHARE != 0)) begin
         ghr_d = GHR_BITS'({ghr_q, resolve_taken_i});
      end

      ras_push      = resolve_valid_i && (resolve_type_i == BP_CALL);
      ras_pop       = resolve_valid_i && (resolve_type_i == BP_RET);
      ras_push_data = resolve_pc_i + 32'd4;
   end

   // Global history register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   // BTB: only the valid bits are cleared; tag/type/target are plain storage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_mem[i].valid <= 1'b0;
         end
      end else if (btb_we) begin
         btb_mem[res_idx] <= btb_wdata;
      end
   end

   // PHT counters start weakly-not-taken and train on every resolved branch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < PHT_ENTRIES; i++) begin
            pht_mem[i] <= CTR_INIT;
         end
      end else if (pht_we) begin
         pht_mem[res_pidx] <= pht_wdata;
      end
   end

   bp_ras #(
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (ras_push),
      .push_data_i (ras_push_data),
      .pop_i       (ras_pop),
      .top_o       (ras_top),
      .empty_o     (ras_empty)
   );

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench: directed scenarios plus a randomized stream, all
// compared against a behavioural model built from plain arrays and a queue.
module tb_branch_predictor_gshare;
   import bp_pkg::*;

   localparam int BTB_ENTRIES  = 64;
   localparam int PHT_ENTRIES  = 512;
   localparam int COUNTER_BITS = 2;
   localparam int GHR_BITS     = 8;
   localparam int USE_GSHARE   = 1;
   localparam int RAS_DEPTH    = 2;

   localparam int CTR_MAX   = (1 << COUNTER_BITS) - 1;
   localparam int CTR_INIT  = (COUNTER_BITS <= 1) ? 0 : (1 << (COUNTER_BITS - 1)) - 1;
   localparam int CTR_TAKEN = 1 << (COUNTER_BITS - 1);

   logic                clk = 1'b0;
   logic                rst_n;
   logic [31:0]         pc_i;
   logic                fetch_valid_i;
   logic                predict_taken_o;
   logic [31:0]         predict_target_o;
   logic [GHR_BITS-1:0] predict_ghr_o;
   logic                resolve_valid_i;
   bp_type_t            resolve_type_i;
   logic [31:0]         resolve_pc_i;
   logic [31:0]         resolve_target_i;
   logic                resolve_taken_i;
   logic [GHR_BITS-1:0] resolve_ghr_i;

   branch_predictor_gshare #(
      .BTB_ENTRIES  (BTB_ENTRIES),
      .PHT_ENTRIES  (PHT_ENTRIES),
      .COUNTER_BITS (COUNTER_BITS),
      .GHR_BITS     (GHR_BITS),
      .USE_GSHARE   (USE_GSHARE),
      .RAS_DEPTH    (RAS_DEPTH)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pc_i             (pc_i),
      .fetch_valid_i    (fetch_valid_i),
      .predict_taken_o  (predict_taken_o),
      .predict_target_o (predict_target_o),
      .predict_ghr_o    (predict_ghr_o),
      .resolve_valid_i  (resolve_valid_i),
      .resolve_type_i   (resolve_type_i),
      .resolve_pc_i     (resolve_pc_i),
      .resolve_target_i (resolve_target_i),
      .resolve_taken_i  (resolve_taken_i),
      .resolve_ghr_i    (resolve_ghr_i)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit          m_valid  [BTB_ENTRIES];
   int unsigned m_tag    [BTB_ENTRIES];
   bp_type_t    m_type   [BTB_ENTRIES];
   int unsigned m_target [BTB_ENTRIES];
   int          m_pht    [PHT_ENTRIES];
   int unsigned m_ghr;
   int unsigned m_ras [$];

   int n_checks = 0;
   int n_fail   = 0;

   logic        obs_taken;
   logic [31:0] obs_target;
   logic [31:0] obs_ghr;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < BTB_ENTRIES; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < PHT_ENTRIES; i++) m_pht[i] = CTR_INIT;
      m_ghr = 0;
      m_ras.delete();
   endtask

   task automatic model_update(input bp_type_t t, input int unsigned rpc, input int unsigned tgt,
                               input bit tk, input int unsigned rg);
      int unsigned p, b;
      if (t == BP_BR) begin
         p = ((rpc >> 1) % PHT_ENTRIES) ^ (USE_GSHARE != 0 ? rg : 0);
         if (tk && m_pht[p] < CTR_MAX) m_pht[p]++;
         if (!tk && m_pht[p] > 0)      m_pht[p]--;
         if (USE_GSHARE != 0) m_ghr = ((m_ghr << 1) | tk) % (1 << GHR_BITS);
      end
      if (tk) begin
         b = (rpc >> 1) % BTB_ENTRIES;
         m_valid[b]  = 1'b1;
         m_tag[b]    = rpc / (2 * BTB_ENTRIES);
         m_type[b]   = t;
         m_target[b] = tgt;
      end
      if (t == BP_CALL) begin
         m_ras.push_back(rpc + 4);
         if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (t == BP_RET && m_ras.size() > 0) begin
         void'(m_ras.pop_back());
      end
   endtask

   task automatic model_predict(input int unsigned fpc, input bit fv,
                                output bit hit, output bit et, output int unsigned etgt);
      int unsigned b, p;
      b    = (fpc >> 1) % BTB_ENTRIES;
      p    = ((fpc >> 1) % PHT_ENTRIES) ^ m_ghr;
      hit  = fv && m_valid[b] && (m_tag[b] == fpc / (2 * BTB_ENTRIES));
      et   = 1'b0;
      etgt = 0;
      if (hit) begin
         etgt = m_target[b];
         if (m_type[b] == BP_BR) begin
            et = (m_pht[p] >= CTR_TAKEN);
         end else begin
            et = 1'b1;
            if (m_type[b] == BP_RET && m_ras.size() > 0) etgt = m_ras[m_ras.size() - 1];
         end
      end
   endtask

   // One cycle: drive at negedge, compare against the model, then commit at posedge.
   task automatic step(input logic rst, input logic fv, input logic [31:0] fpc,
                       input logic rv, input bp_type_t rt, input logic [31:0] rpc,
                       input logic [31:0] rtgt, input logic rtk, input logic [GHR_BITS-1:0] rg);
      bit hit, et;
      int unsigned etgt;
      @(negedge clk);
      rst_n            = rst;
      fetch_valid_i    = fv;
      pc_i             = fpc;
      resolve_valid_i  = rv;
      resolve_type_i   = rt;
      resolve_pc_i     = rpc;
      resolve_target_i = rtgt;
      resolve_taken_i  = rtk;
      resolve_ghr_i    = rg;
      #1;
      model_predict(fpc, fv, hit, et, etgt);
      check_val("model_taken", {31'b0, predict_taken_o}, {31'b0, et});
      if (et || !hit) check_val("model_target", predict_target_o, etgt);
      check_val("model_ghr", 32'(predict_ghr_o), m_ghr);
      obs_taken  = predict_taken_o;
      obs_target = predict_target_o;
      obs_ghr    = 32'(predict_ghr_o);
      @(posedge clk);
      if (!rst)    model_reset();
      else if (rv) model_update(rt, rpc, rtgt, rtk, rg);
   endtask

   task automatic resolve(input bp_type_t t, input logic [31:0] rpc, input logic [31:0] tgt,
                          input logic tk, input logic [GHR_BITS-1:0] rg);
      step(1'b1, 1'b0, 32'h0, 1'b1, t, rpc, tgt, tk, rg);
   endtask

   task automatic probe_expect(input string tag, input logic [31:0] fpc,
                               input logic et, input logic [31:0] etgt);
      step(1'b1, 1'b1, fpc, 1'b0, BP_BR, 32'h0, 32'h0, 1'b0, '0);
      check_val({tag, "_taken"}, {31'b0, obs_taken}, {31'b0, et});
      check_val({tag, "_target"}, obs_target, etgt);
   endtask

   function automatic logic [31:0] pick_pc();
      if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
      return 32'h1000 + ($urandom_range(0, 15) << 1) + ($urandom_range(0, 1) << 7);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bp_type_t rt;
      logic     rtk;
      rst_n            = 1'b0;
      fetch_valid_i    = 1'b0;
      pc_i             = '0;
      resolve_valid_i  = 1'b0;
      resolve_type_i   = BP_BR;
      resolve_pc_i     = '0;
      resolve_target_i = '0;
      resolve_taken_i  = 1'b0;
      resolve_ghr_i    = '0;
      model_reset();
      repeat (3) @(posedge clk);

      // Reset state
      probe_expect("reset_pc100", 32'h100, 1'b0, 32'h0);
      check_val("reset_ghr", obs_ghr, 32'h0);

      // Fill GHR with ones, then saturate the counter used by fetch at 0x200
      for (int i = 0; i < 8; i++) resolve(BP_BR, 32'h302, 32'h3000, 1'b1, 8'hFF);
      for (int i = 0; i < 7; i++) resolve(BP_BR, 32'h200, 32'h180, 1'b1, 8'hFF);
      probe_expect("br_sat_taken", 32'h200, 1'b1, 32'h180);
      check_val("ghr_all_taken", obs_ghr, 32'hFF);
      for (int i = 0; i < 2; i++) resolve(BP_BR, 32'h200, 32'h180, 1'b0, 8'hFF);
      step(1'b1, 1'b1, 32'h200, 1'b0, BP_BR, 32'h0, 32'h0, 1'b0, '0);
      for (int i = 0; i < 6; i++) resolve(BP_BR, 32'h302, 32'h3000, 1'b0, 8'h00);
      step(1'b1, 1'b1, 32'h302, 1'b0, BP_BR, 32'h0, 32'h0, 1'b0, '0);

      // RAS: RET falls back to BTB when empty, follows CALL return address otherwise
      resolve(BP_RET, 32'h500, 32'h999, 1'b1, '0);
      resolve(BP_CALL, 32'h410, 32'h4000, 1'b1, '0);
      probe_expect("ras_after_call", 32'h500, 1'b1, 32'h414);
      resolve(BP_RET, 32'h500, 32'h999, 1'b1, '0);
      probe_expect("ras_empty_fallback", 32'h500, 1'b1, 32'h999);

      // RAS overflow overwrites the oldest entry; underflow is a no-op
      resolve(BP_CALL, 32'h10, 32'h8000, 1'b1, '0);
      resolve(BP_CALL, 32'h20, 32'h8000, 1'b1, '0);
      resolve(BP_CALL, 32'h30, 32'h8000, 1'b1, '0);
      probe_expect("ras_top_newest", 32'h500, 1'b1, 32'h34);
      resolve(BP_RET, 32'h500, 32'h999, 1'b1, '0);
      probe_expect("ras_second", 32'h500, 1'b1, 32'h24);
      resolve(BP_RET, 32'h500, 32'h999, 1'b1, '0);
      probe_expect("ras_oldest_lost", 32'h500, 1'b1, 32'h999);
      resolve(BP_RET, 32'h500, 32'h999, 1'b1, '0);
      probe_expect("ras_underflow", 32'h500, 1'b1, 32'h999);
      resolve(BP_CALL, 32'h40, 32'h8000, 1'b1, '0);
      probe_expect("ras_after_underflow", 32'h500, 1'b1, 32'h44);

      // Aliasing: a later taken op at the same index replaces the entry
      resolve(BP_JAL, 32'h200, 32'h1000, 1'b1, '0);
      resolve(BP_JAL, 32'h280, 32'h2000, 1'b1, '0);
      probe_expect("alias_evicted", 32'h200, 1'b0, 32'h0);
      probe_expect("alias_owner", 32'h280, 1'b1, 32'h2000);

      // fetch_valid_i low suppresses the prediction
      step(1'b1, 1'b0, 32'h280, 1'b0, BP_BR, 32'h0, 32'h0, 1'b0, '0);
      check_val("fetch_gate_taken", {31'b0, obs_taken}, 32'h0);
      check_val("fetch_gate_target", obs_target, 32'h0);

      // Reset beats a same-cycle resolve
      step(1'b0, 1'b1, 32'h280, 1'b1, BP_JAL, 32'h600, 32'h777, 1'b1, '0);
      probe_expect("rst_no_write", 32'h600, 1'b0, 32'h0);
      probe_expect("rst_clears_btb", 32'h280, 1'b0, 32'h0);
      check_val("rst_clears_ghr", obs_ghr, 32'h0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rt  = bp_type_t'($urandom_range(0, 4));
         rtk = (rt == BP_BR) ? 1'($urandom_range(0, 1)) : 1'b1;
         step(($urandom_range(0, 299) != 0),
              ($urandom_range(0, 9) != 0),
              pick_pc(),
              ($urandom_range(0, 3) != 0),
              rt,
              pick_pc(),
              $urandom,
              rtk,
              ($urandom_range(0, 1) != 0) ? GHR_BITS'(m_ghr) : GHR_BITS'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
